array_rw_ctrl: RTL and testbench



---
 rtl/array_rw_ctrl_if.sv | 29 ++
 rtl/array_rw_ctrl.sv | 117 +++++++++++
 tb/tb_array_rw_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/array_rw_ctrl_if.sv
// Requester-side bus of array_rw_ctrl: one read channel, one write channel
// and the read-response pulse. The master drives requests; the slave (the
// controller) drives readiness and responses.
interface array_rw_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 148,
  parameter int MASK_W = 2
);
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [MASK_W-1:0] wr_mask;
  logic [DATA_W-1:0] wr_data;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;

  modport master (
    output rd_valid, rd_addr, wr_valid, wr_addr, wr_mask, wr_data,
    input  rd_ready, wr_ready, resp_valid, resp_data
  );

  modport slave (
    input  rd_valid, rd_addr, wr_valid, wr_addr, wr_mask, wr_data,
    output rd_ready, wr_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/array_rw_ctrl.sv
// Sequencing controller in front of a single-port 1RW SRAM macro.
// Arbitrates one reader and one writer onto the port (writes win unless the
// reader has been blocked STARVE_LIMIT cycles in a row) and returns read data
// as a pulse one cycle after the read is accepted.
// Optional feature macro: ARRAY_CTRL_INIT_EN -- when defined, the array is
// swept to zero for DEPTH cycles after reset; otherwise INIT lasts one idle
// cycle and the array contents are left as found.
module array_rw_ctrl #(
  parameter int DEPTH        = 32,
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 148,
  parameter int MASK_W       = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  array_rw_ctrl_if.slave    req,
  output logic              init_done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

`ifdef ARRAY_CTRL_INIT_EN
  localparam bit INIT_SWEEP = 1'b1;
`else
  localparam bit INIT_SWEEP = 1'b0;
`endif

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] init_cnt;
  logic [3:0]        starve_cnt;
  logic              resp_valid_q;
  logic              starve_flag;
  logic              init_last;
  logic              rd_fire;
  logic              wr_fire;

  assign starve_flag = (starve_cnt >= 4'(STARVE_LIMIT));
  assign init_last   = INIT_SWEEP ? (init_cnt == ADDR_W'(DEPTH - 1)) : 1'b1;

  // Handshake readiness: nothing is accepted until the controller reaches RUN.
  assign req.wr_ready = (state == ST_RUN) && !(req.rd_valid && starve_flag);
  assign req.rd_ready = (state == ST_RUN) && (!req.wr_valid || starve_flag);

  // The two ready terms are mutually exclusive whenever both valids are high,
  // so at most one of these fires in a cycle.
  assign wr_fire = req.wr_valid && req.wr_ready;
  assign rd_fire = req.rd_valid && req.rd_ready;

  // The macro holds rdata until the next read, so it is forwarded directly.
  assign req.resp_valid = resp_valid_q;
  assign req.resp_data  = sram_rdata;

  // Macro port mux: init sweep, accepted write, accepted read, or fully idle.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned
    // and infers a latch.
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wmask = '0;
    sram_wdata = '0;
    if (state == ST_INIT) begin
      if (INIT_SWEEP) begin
        sram_en    = 1'b1;
        sram_wmode = 1'b1;
        sram_addr  = init_cnt;
        sram_wmask = '1;
      end
    end else if (wr_fire) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = req.wr_addr;
      sram_wmask = req.wr_mask;
      sram_wdata = req.wr_data;
    end else if (rd_fire) begin
      sram_en   = 1'b1;
      sram_addr = req.rd_addr;
    end
  end

  // Controller state: init sequencing, read-starvation counter, response pulse.
  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      state        <= ST_INIT;
      init_cnt     <= '0;
      starve_cnt   <= '0;
      resp_valid_q <= 1'b0;
      init_done    <= 1'b0;
    end else begin
      resp_valid_q <= rd_fire;
      if (state == ST_INIT) begin
        init_cnt <= init_cnt + 1'b1;
        if (init_last) begin
          state     <= ST_RUN;
          init_done <= 1'b1;
        end
      end else begin
        if (rd_fire || !req.rd_valid) begin
          starve_cnt <= '0;
        end else if (starve_cnt != 4'hF) begin
          starve_cnt <= starve_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_array_rw_ctrl.sv
// Self-checking bench for array_rw_ctrl. A behavioural SRAM macro sits on the
// macro port; a separate reference model (expected array contents, arbitration
// rule, pending response) predicts every observable output each cycle.
`timescale 1ns/1ps
module tb_array_rw_ctrl;
  localparam int DEPTH        = 32;
  localparam int ADDR_W       = 5;
  localparam int DATA_W       = 148;
  localparam int MASK_W       = 2;
  localparam int STARVE_LIMIT = 4;
  localparam int LANE_W       = DATA_W / MASK_W;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              init_done;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_en;
  logic              sram_wmode;
  logic [MASK_W-1:0] sram_wmask;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  array_rw_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) bus ();

  array_rw_ctrl #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (bus),
    .init_done  (init_done),
    .sram_addr  (sram_addr),
    .sram_en    (sram_en),
    .sram_wmode (sram_wmode),
    .sram_wmask (sram_wmask),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  always #5 clock = ~clock;

  // Behavioural 1RW macro: masked write, 1-cycle read, rdata held between reads.
  logic [DATA_W-1:0] sram_mem [DEPTH];
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) begin
        for (int l = 0; l < MASK_W; l++)
          if (sram_wmask[l]) sram_mem[sram_addr][l*LANE_W +: LANE_W] <= sram_wdata[l*LANE_W +: LANE_W];
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  // Reference model state
  logic [DATA_W-1:0] ref_mem   [DEPTH];
  logic [MASK_W-1:0] ref_known [DEPTH];
  int                m_starve;
  bit                m_run;
  int                m_init_cnt;
  bit                m_resp_pend;
  bit                m_resp_known;
  logic [DATA_W-1:0] m_resp_data;

  int errors = 0;
  int checks = 0;
  bit obs_rd_fire, obs_wr_fire;

  function automatic logic [DATA_W-1:0] rand_data();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[DATA_W-1:0];
  endfunction

  task automatic model_reset();
    m_starve    = 0;
    m_run       = 1'b0;
    m_init_cnt  = 0;
    m_resp_pend = 1'b0;
  endtask

  // One clock cycle: drive, sample at the falling edge against the model,
  // advance the model, then move to just after the next rising edge.
  task automatic cycle(input bit rv, input logic [ADDR_W-1:0] ra,
                       input bit wv, input logic [ADDR_W-1:0] wa,
                       input logic [MASK_W-1:0] wm, input logic [DATA_W-1:0] wd);
    bit starved, exp_rr, exp_wr, wf, rf;
    logic [DATA_W+ADDR_W+MASK_W+1:0] exp_port, got_port;
    bus.rd_valid = rv; bus.rd_addr = ra;
    bus.wr_valid = wv; bus.wr_addr = wa; bus.wr_mask = wm; bus.wr_data = wd;
    @(negedge clock);
    // A write is served unless a read that has already waited STARVE_LIMIT
    // cycles is present; a read is served unless a non-starved write competes.
    starved = m_run && (m_starve >= STARVE_LIMIT);
    exp_wr  = m_run && !(rv && starved);
    exp_rr  = m_run && (!wv || starved);
    wf = wv && exp_wr;
    rf = rv && exp_rr;
    exp_port = '0;
    if (!m_run) begin
`ifdef ARRAY_CTRL_INIT_EN
      exp_port = {1'b1, 1'b1, ADDR_W'(m_init_cnt), {MASK_W{1'b1}}, {DATA_W{1'b0}}};
`endif
    end else if (wf) begin
      exp_port = {1'b1, 1'b1, wa, wm, wd};
    end else if (rf) begin
      exp_port = {1'b1, 1'b0, ra, {MASK_W{1'b0}}, {DATA_W{1'b0}}};
    end
    got_port = {sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata};

    checks++;
    if (bus.rd_ready !== exp_rr) begin
      errors++; $display("FAIL rd_ready t=%0t got=%b exp=%b", $time, bus.rd_ready, exp_rr);
    end
    checks++;
    if (bus.wr_ready !== exp_wr) begin
      errors++; $display("FAIL wr_ready t=%0t got=%b exp=%b", $time, bus.wr_ready, exp_wr);
    end
    checks++;
    if (init_done !== m_run) begin
      errors++; $display("FAIL init_done t=%0t got=%b exp=%b", $time, init_done, m_run);
    end
    checks++;
    if (bus.resp_valid !== m_resp_pend) begin
      errors++; $display("FAIL resp_valid t=%0t got=%b exp=%b", $time, bus.resp_valid, m_resp_pend);
    end
    if (m_resp_pend && m_resp_known) begin
      checks++;
      if (bus.resp_data !== m_resp_data) begin
        errors++; $display("FAIL resp_data t=%0t got=%h exp=%h", $time, bus.resp_data, m_resp_data);
      end
    end
    checks++;
    if (got_port !== exp_port) begin
      errors++; $display("FAIL sram_port t=%0t got=%h exp=%h", $time, got_port, exp_port);
    end
    obs_rd_fire = rv && (bus.rd_ready === 1'b1);
    obs_wr_fire = wv && (bus.wr_ready === 1'b1);

    // Advance the model
    m_resp_pend = rf;
    if (rf) begin
      m_resp_data  = ref_mem[ra];
      m_resp_known = (ref_known[ra] == {MASK_W{1'b1}});
    end
    if (wf) begin
      for (int l = 0; l < MASK_W; l++) begin
        if (wm[l]) begin
          ref_mem[wa][l*LANE_W +: LANE_W] = wd[l*LANE_W +: LANE_W];
          ref_known[wa][l] = 1'b1;
        end
      end
    end
    if (!m_run) begin
`ifdef ARRAY_CTRL_INIT_EN
      ref_mem[m_init_cnt]   = '0;
      ref_known[m_init_cnt] = '1;
      m_init_cnt++;
      if (m_init_cnt == DEPTH) m_run = 1'b1;
`else
      m_run = 1'b1;
`endif
    end else if (!rv || rf) begin
      m_starve = 0;
    end else if (m_starve < 15) begin
      m_starve++;
    end
    @(posedge clock); #1;
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, '0, '0, '0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    bus.rd_valid = 1'b0; bus.wr_valid = 1'b0;
    repeat (n) @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
  endtask

  // Idle cycles until the model says RUN, bounded; returns INIT length.
  task automatic run_init(output int n);
    n = 0;
    while (!m_run && n < 2 * DEPTH + 4) begin
      idle();
      n++;
    end
  endtask

  task automatic test_reset();
    do_reset(2);
    checks++;
    if (bus.resp_valid !== 1'b0 || init_done !== 1'b0) begin
      errors++; $display("FAIL reset_state resp_valid=%b init_done=%b exp=0/0", bus.resp_valid, init_done);
    end
  endtask

  task automatic test_init_sweep();
    int n;
    int exp_n;
`ifdef ARRAY_CTRL_INIT_EN
    exp_n = DEPTH;
`else
    exp_n = 1;
`endif
    run_init(n);
    checks++;
    if (n !== exp_n || init_done !== 1'b1) begin
      errors++; $display("FAIL init_length got=%0d cycles init_done=%b exp=%0d/1", n, init_done, exp_n);
    end
`ifdef ARRAY_CTRL_INIT_EN
    cycle(1'b1, 5'd7, 1'b0, '0, '0, '0);
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== '0) begin
      errors++; $display("FAIL init_zero_rd7 valid=%b data=%h exp=1/0", bus.resp_valid, bus.resp_data);
    end
    idle();
`endif
  endtask

  task automatic test_write_read();
    logic [DATA_W-1:0] d;
    d = DATA_W'(16'h1234);
    cycle(1'b0, '0, 1'b1, 5'd5, 2'b11, d);
    cycle(1'b1, 5'd5, 1'b0, '0, '0, '0);
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== d) begin
      errors++; $display("FAIL write_read valid=%b data=%h exp=1/%h", bus.resp_valid, bus.resp_data, d);
    end
    idle();
  endtask

  task automatic test_partial_mask();
    logic [DATA_W-1:0] exp_d;
    exp_d = {{LANE_W{1'b1}}, {LANE_W{1'b0}}};
    cycle(1'b0, '0, 1'b1, 5'd3, 2'b11, '1);
    cycle(1'b0, '0, 1'b1, 5'd3, 2'b01, '0);
    cycle(1'b1, 5'd3, 1'b0, '0, '0, '0);
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== exp_d) begin
      errors++; $display("FAIL partial_mask valid=%b data=%h exp=1/%h", bus.resp_valid, bus.resp_data, exp_d);
    end
    // A zero-mask write is accepted but leaves the entry untouched.
    cycle(1'b0, '0, 1'b1, 5'd3, 2'b00, rand_data());
    cycle(1'b1, 5'd3, 1'b0, '0, '0, '0);
    checks++;
    if (bus.resp_data !== exp_d) begin
      errors++; $display("FAIL zero_mask data=%h exp=%h", bus.resp_data, exp_d);
    end
    idle();
  endtask

  task automatic test_contention();
    bit exp_rd;
    idle();
    for (int i = 0; i < 15; i++) begin
      cycle(1'b1, 5'd9, 1'b1, ADDR_W'(10 + (i % 4)), 2'b11, rand_data());
      exp_rd = ((i % 5) == 4);
      checks++;
      if (obs_rd_fire !== exp_rd || obs_wr_fire !== !exp_rd) begin
        errors++; $display("FAIL contention i=%0d rd_fire=%b wr_fire=%b exp_rd=%b", i, obs_rd_fire, obs_wr_fire, exp_rd);
      end
    end
    idle();
  endtask

  task automatic test_idle();
    repeat (10) idle();
    checks++;
    if (sram_en !== 1'b0 || bus.rd_ready !== 1'b1 || bus.wr_ready !== 1'b1) begin
      errors++; $display("FAIL idle en=%b rd_ready=%b wr_ready=%b exp=0/1/1", sram_en, bus.rd_ready, bus.wr_ready);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 9) < 7, ADDR_W'($urandom_range(0, 7)),
            $urandom_range(0, 9) < 7, ADDR_W'($urandom_range(0, 7)),
            MASK_W'($urandom_range(0, 3)), rand_data());
    end
    idle();
  endtask

  task automatic test_reset_mid();
    int n;
`ifdef ARRAY_CTRL_INIT_EN
    do_reset(1);
    repeat (10) idle();
    do_reset(1);
    run_init(n);
    checks++;
    if (n !== DEPTH) begin
      errors++; $display("FAIL sweep_restart got=%0d cycles exp=%0d", n, DEPTH);
    end
`endif
    // Read handshake presented on the very edge reset is sampled: no response.
    cycle(1'b0, '0, 1'b1, 5'd4, 2'b11, rand_data());
    reset = 1'b1;
    bus.rd_valid = 1'b1; bus.rd_addr = 5'd4; bus.wr_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    bus.rd_valid = 1'b0;
    model_reset();
    checks++;
    if (bus.resp_valid !== 1'b0 || init_done !== 1'b0) begin
      errors++; $display("FAIL reset_drop_resp resp_valid=%b init_done=%b exp=0/0", bus.resp_valid, init_done);
    end
    run_init(n);
    test_write_read();
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) ref_known[a] = '0;
    model_reset();
    bus.rd_valid = 1'b0; bus.rd_addr = '0;
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_mask = '0; bus.wr_data = '0;
    test_reset();
    test_init_sweep();
    test_write_read();
    test_partial_mask();
    test_contention();
    test_idle();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
